// File: rtl/master_port.sv
// Bit-serial bus initiator: one parallel request becomes an address/data stream to a slave port.
// Optional read-wait timeout is built when MASTER_TIMEOUT_EN is defined.
module master_port #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_mode,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  wr_bus,
  output logic                  mode,
  output logic                  master_valid,
  output logic                  master_ready,
  input  logic                  rd_bus,
  input  logic                  slave_ready,
  input  logic                  slave_valid,
  input  logic                  split
);

  localparam int SW = ADDR_WIDTH + DATA_WIDTH;
  localparam int CW = $clog2(SW + 1);
  localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_WIDTH - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, ADDR, WDATA, WPAD, RDATA, DONE} state_t;

  state_t                  state_reg, state_next;
  logic [SW-1:0]           shift_reg, shift_next;
  logic [DATA_WIDTH-1:0]   rx_reg, rx_next;
  logic [DATA_WIDTH-1:0]   rdata_reg, rdata_next;
  logic [DATA_WIDTH-1:0]   rx_shift;
  logic [CW-1:0]           cnt_reg, cnt_next;
  logic                    mode_reg, mode_next;
  logic                    timeout_hit;

  assign rx_shift = {rx_reg[DATA_WIDTH-2:0], rd_bus};

  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    rx_next    = rx_reg;
    rdata_next = rdata_reg;
    cnt_next   = cnt_reg;
    mode_next  = mode_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          shift_next = {req_addr, req_wdata};
          mode_next  = req_mode;
          rx_next    = '0;
          cnt_next   = '0;
          state_next = ADDR;
        end
      end
      ADDR: begin
        if (slave_ready) begin
          shift_next = shift_reg << 1;
          if (cnt_reg == ADDR_LAST) begin
            cnt_next   = '0;
            state_next = mode_reg ? WDATA : RDATA;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      WDATA: begin
        if (slave_ready) begin
          shift_next = shift_reg << 1;
          if (cnt_reg == DATA_LAST) begin
            cnt_next   = '0;
            state_next = WPAD;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      WPAD: begin
        if (slave_ready) begin
          cnt_next   = '0;
          state_next = DONE;
        end
      end
      RDATA: begin
        if (slave_valid) begin
          rx_next = rx_shift;
          if (cnt_reg == DATA_LAST) begin
            rdata_next = rx_shift;
            cnt_next   = '0;
            state_next = DONE;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end else if (timeout_hit) begin
          cnt_next   = '0;
          state_next = DONE;
        end
      end
      DONE: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      shift_reg <= '0;
      rx_reg    <= '0;
      rdata_reg <= '0;
      cnt_reg   <= '0;
      mode_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      rx_reg    <= rx_next;
      rdata_reg <= rdata_next;
      cnt_reg   <= cnt_next;
      mode_reg  <= mode_next;
    end
  end

`ifdef MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] wait_reg;
  logic          err_reg;

  // Fires on the cycle the idle count would reach TIMEOUT_CYCLES; split freezes it.
  assign timeout_hit = (state_reg == RDATA) && !slave_valid && !split && (wait_reg == WAIT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_reg <= '0;
      err_reg  <= 1'b0;
    end else begin
      if (state_reg != RDATA || slave_valid) begin
        wait_reg <= '0;
      end else if (!split) begin
        wait_reg <= wait_reg + 1'b1;
      end
      if (state_reg == IDLE) begin
        err_reg <= 1'b0;
      end else if (timeout_hit) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign resp_err = err_reg && (state_reg == DONE);
`else
  logic unused_cfg;
  assign timeout_hit = 1'b0;
  assign resp_err    = 1'b0;
  assign unused_cfg  = split ^ (TIMEOUT_CYCLES > 0);
`endif

  assign req_ready    = (state_reg == IDLE);
  assign master_valid = (state_reg == ADDR) || (state_reg == WDATA) || (state_reg == WPAD);
  assign wr_bus       = ((state_reg == ADDR) || (state_reg == WDATA)) && shift_reg[SW-1];
  assign mode         = master_valid && mode_reg;
  assign master_ready = (state_reg == RDATA);
  assign resp_valid   = (state_reg == DONE);
  assign resp_rdata   = rdata_reg;

endmodule
